tremolo_lfo: RTL and testbench
==============================

// Module: tremolo_lfo
// PURPOSE
//  Low-frequency triangle generator for the tremolo path; sits directly upstream of the
//  tremolo shift table. On each input sample strobe it registers the sample and emits it
//  with a 3-bit attenuation index (0 = unity, 7 = x>>>7) and a registered enable.
//  The index ramps 0..depth..0 at a programmable rate counted in samples.
// PARAMETERS
//  DATA_WIDTH  32  signed audio sample width
//  RATE_WIDTH  16  width of the rate (prescaler) input
// PORTS
//  clk       in   1           system clock
//  rst_n     in   1           asynchronous, active-low reset
//  en        in   1           tremolo enable
//  rate      in   RATE_WIDTH  LFO step period minus one, in accepted samples
//  depth     in   3           peak attenuation index (triangle apex)
//  s_valid   in   1           input sample strobe, single-cycle, no backpressure
//  x_in      in   DATA_WIDTH  signed input sample
//  m_valid   out  1           output sample strobe
//  x_out     out  DATA_WIDTH  registered sample, aligned with counter/en_out
//  counter   out  3           attenuation index for x_out
//  en_out    out  1           enable for x_out (drives the shift table's en)
// BEHAVIOUR
//  - Reset: m_valid=0, x_out=0, counter=0, en_out=0; FSM=IDLE, phase=0, presc=0.
//  - Latency 1 clk: cycle after s_valid -> m_valid=1 for exactly 1 clk, x_out=x_in,
//    en_out=en, counter=phase value before this sample's update. Outputs hold otherwise.
//  - Prescaler (only when en=1, counts s_valid): if presc>=rate -> presc=0, step pulse;
//    else presc+1. Using >= makes a mid-run rate decrease wrap on the next sample.
//    rate=0 -> step on every sample.
//  - FSM states IDLE, RISE, FALL; transitions evaluated only on a step pulse except as noted:
//    IDLE: phase=0, presc=0. en=1 -> RISE (next clk, no step consumed).
//    RISE: phase+1; if phase+1>=depth -> FALL.  FALL: phase-1; if phase-1==0 -> RISE.
//    depth==0: phase held 0, state stays RISE.
//    phase>depth at a step (depth lowered mid-run): phase=depth, state=FALL.
//    en=0 in any state -> IDLE next clk, phase=0, presc=0 (no waiting for a step).
//  - depth=2, rate=0 index sequence: 0,1,2,1,0,1,2,...  depth=1: 0,1,0,1,...
//  - Simultaneous s_valid and en falling: sample output with en_out=0, counter=0.
//    s_valid on the cycle en rises: en_out=1, counter=0; prescaler starts counting from it.
//  - Reset asserted mid-run: all state and outputs clear at once; a sample in flight is
//    dropped (no m_valid).
//  - No arithmetic on the sample; x_out is a bit-exact copy. phase is 3-bit, never wraps
//    (bounded by depth<=7).
// STRUCTURE
//  - tremolo_pkg: COUNTER_WIDTH=3 constant; typedef lfo_state_t {IDLE, RISE, FALL}.
//  - Sub-module tremolo_prescaler: presc counter, rate compare, step output, clear input
//    (driven by IDLE); FSM and output registers stay in tremolo_lfo.
//  - Outputs connect directly to the shift table's counter/en/x ports.
// TESTING
//  1. Reset: hold rst_n=0 with s_valid pulsing -> m_valid=0, x_out=0, counter=0, en_out=0.
//  2. en=1, rate=0, depth=2, 8 samples x_in=1000 -> counter 0,1,2,1,0,1,2,1; x_out=1000.
//  3. en=1, rate=3, depth=7 -> counter changes every 4th sample, peaks at 7, falls to 0.
//  4. Mid-run at phase=5 set depth=3 -> next step gives counter=3 in FALL, then 2,1,0,1.
//  5. en drops at phase=4 on the same cycle as s_valid -> that sample en_out=0, counter=0;
//     re-enable -> restart at 0 in RISE.
//  6. Async rst_n pulse between s_valid and m_valid -> no m_valid; post-reset counter=0.

Source files
------------

// File: rtl/tremolo_lfo_pkg.sv
// Shared types and constants for the tremolo LFO and its sub-blocks.
package tremolo_pkg;

    // Width of the attenuation index handed to the shift table.
    localparam int COUNTER_WIDTH = 3;

    // Triangle generator states: parked, ramping up, ramping down.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } lfo_state_t;

endpackage

// File: rtl/tremolo_lfo_if.sv
// Sample stream bus between the upstream source, the LFO and the shift table.
interface tremolo_lfo_if #(
    parameter int DATA_WIDTH = 32
);
    import tremolo_pkg::*;

    logic                     s_valid;
    logic [DATA_WIDTH-1:0]    x_in;
    logic                     m_valid;
    logic [DATA_WIDTH-1:0]    x_out;
    logic [COUNTER_WIDTH-1:0] counter;
    logic                     en_out;

    // Sample source side: drives input samples, observes the annotated output.
    modport master (
        output s_valid, x_in,
        input  m_valid, x_out, counter, en_out
    );

    // LFO side: consumes input samples, produces the annotated output.
    modport slave (
        input  s_valid, x_in,
        output m_valid, x_out, counter, en_out
    );

endinterface

// File: rtl/tremolo_lfo_prescaler.sv
// Sample-counting prescaler: emits a one-cycle step after every (rate+1)
// counted samples. A clear forces the count back to zero, but a sample
// arriving in the same cycle is still counted from zero, so the first
// sample after enabling is the first one of the period.
module tremolo_prescaler #(
    parameter int RATE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  count,
    input  logic [RATE_WIDTH-1:0] rate,
    output logic                  step
);

    logic [RATE_WIDTH-1:0] presc_q;
    logic [RATE_WIDTH-1:0] presc_d;
    logic [RATE_WIDTH-1:0] presc_base;

    // Next count; >= so a rate lowered below the current count wraps at once.
    always_comb begin
        presc_base = clear ? '0 : presc_q;
        presc_d    = presc_base;
        step       = 1'b0;
        if (count) begin
            if (presc_base >= rate) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_base + {{(RATE_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/tremolo_lfo.sv
// Triangle LFO for the tremolo path. Each input sample is registered and
// emitted one clock later together with the attenuation index that was
// current when it arrived and the enable that was present with it.
module tremolo_lfo
    import tremolo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RATE_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [RATE_WIDTH-1:0]    rate,
    input  logic [COUNTER_WIDTH-1:0] depth,
    tremolo_lfo_if.slave             bus
);

    lfo_state_t               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] phase_q, phase_d;
    logic [COUNTER_WIDTH:0]   phase_inc;
    logic [COUNTER_WIDTH-1:0] phase_dec;
    logic                     step;
    logic                     presc_clear;

    logic                     m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]    x_out_q, x_out_d;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic                     en_out_q, en_out_d;

    // The prescaler is held at zero while parked or disabled.
    assign presc_clear = (state_q == IDLE) || !en;

    tremolo_prescaler #(
        .RATE_WIDTH (RATE_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .count (bus.s_valid && en),
        .rate  (rate),
        .step  (step)
    );

    assign phase_inc = {1'b0, phase_q} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    assign phase_dec = phase_q - {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    // Triangle sequencing. Leaving IDLE costs no step, so a step arriving in
    // the same cycle as the enable is applied as the first rising step.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (!en) begin
            state_d = IDLE;
            phase_d = '0;
        end else begin
            if (state_q == IDLE) begin
                state_d = RISE;
            end
            if (step) begin
                if (depth == '0) begin
                    phase_d = '0;
                    state_d = RISE;
                end else if (phase_q > depth) begin
                    // Depth was lowered under the current phase: snap to apex.
                    phase_d = depth;
                    state_d = FALL;
                end else if (state_d == RISE) begin
                    phase_d = phase_inc[COUNTER_WIDTH-1:0];
                    if (phase_inc >= {1'b0, depth}) begin
                        state_d = FALL;
                    end
                end else begin
                    phase_d = phase_dec;
                    if (phase_dec == '0) begin
                        state_d = RISE;
                    end
                end
            end
        end
    end

    // Output capture: outputs only change on a sample and hold otherwise.
    always_comb begin
        m_valid_d = bus.s_valid;
        x_out_d   = x_out_q;
        counter_d = counter_q;
        en_out_d  = en_out_q;
        if (bus.s_valid) begin
            x_out_d   = bus.x_in;
            counter_d = en ? phase_q : '0;
            en_out_d  = en;
        end
    end

    // State and output registers; reset drops any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            m_valid_q <= 1'b0;
            x_out_q   <= '0;
            counter_q <= '0;
            en_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            m_valid_q <= m_valid_d;
            x_out_q   <= x_out_d;
            counter_q <= counter_d;
            en_out_q  <= en_out_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.x_out   = x_out_q;
    assign bus.counter = counter_q;
    assign bus.en_out  = en_out_q;

endmodule

// File: tb/tb_tremolo_lfo.sv
// Directed and randomized checks of the tremolo LFO against a sample-level
// reference model of the triangle (phase + direction + sample countdown).
module tb_tremolo_lfo;
    import tremolo_pkg::*;

    localparam int DW = 32;
    localparam int RW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic [RW-1:0] rate  = '0;
    logic [2:0]    depth = '0;

    tremolo_lfo_if #(.DATA_WIDTH(DW)) bus ();

    tremolo_lfo #(
        .DATA_WIDTH (DW),
        .RATE_WIDTH (RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .rate  (rate),
        .depth (depth),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase value, direction, samples seen in this period.
    int          m_phase;
    bit          m_down;
    int          m_presc;
    logic [31:0] m_x;
    int          m_cnt;
    bit          m_en_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_down   = 0;
        m_presc  = 0;
        m_x      = '0;
        m_cnt    = 0;
        m_en_out = 0;
    endtask

    // One LFO step on the abstract triangle.
    task automatic model_step();
        int d;
        d = int'(depth);
        if (d == 0) begin
            m_phase = 0;
            m_down  = 0;
        end else if (m_phase > d) begin
            m_phase = d;
            m_down  = 1;
        end else if (!m_down) begin
            m_phase = m_phase + 1;
            if (m_phase >= d) m_down = 1;
        end else begin
            m_phase = m_phase - 1;
            if (m_phase == 0) m_down = 0;
        end
    endtask

    // Model of one clock given the inputs present at the edge.
    task automatic model_cycle(input bit sv, input logic [31:0] x);
        if (!en) begin
            if (sv) begin
                m_x      = x;
                m_cnt    = 0;
                m_en_out = 0;
            end
            m_phase = 0;
            m_down  = 0;
            m_presc = 0;
        end else if (sv) begin
            m_x      = x;
            m_cnt    = m_phase;
            m_en_out = 1;
            if (m_presc >= int'(rate)) begin
                m_presc = 0;
                model_step();
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    // Drive one clock, update the model at the edge, check just after it.
    task automatic cyc(input bit sv, input logic [31:0] x);
        bus.s_valid = sv;
        bus.x_in    = x;
        @(posedge clk);
        model_cycle(sv, x);
        #1;
        check("m_valid", 32'(bus.m_valid), 32'(sv));
        check("x_out",   bus.x_out, m_x);
        check("counter", 32'(bus.counter), 32'(m_cnt));
        check("en_out",  32'(bus.en_out), 32'(m_en_out));
        if (sv)
            $display("sample x=%08h en=%0d rate=%0d depth=%0d -> counter=%0d en_out=%0d",
                     x, en, rate, depth, bus.counter, bus.en_out);
    endtask

    int exp2 [8] = '{0, 1, 2, 1, 0, 1, 2, 1};
    int exp4 [6] = '{5, 3, 2, 1, 0, 1};

    initial begin
        bus.s_valid = 1'b0;
        bus.x_in    = '0;
        model_reset();

        // Reset held with samples pulsing: nothing comes out.
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.x_in    = $urandom;
            @(posedge clk);
            #1;
            check("rst_m_valid", 32'(bus.m_valid), 32'd0);
            check("rst_x_out",   bus.x_out, 32'd0);
            check("rst_counter", 32'(bus.counter), 32'd0);
            check("rst_en_out",  32'(bus.en_out), 32'd0);
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // depth=2, rate=0: 0,1,2,1,0,1,2,1.
        en = 1'b1; rate = 0; depth = 3'd2;
        cyc(0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'd1000);
            check("t2_seq", 32'(bus.counter), 32'(exp2[i]));
            check("t2_x",   bus.x_out, 32'd1000);
        end

        // depth=7, rate=3: index moves every 4th sample, period 14 steps.
        en = 1'b0;
        cyc(0, 0);
        en = 1'b1; rate = 3; depth = 3'd7;
        for (int k = 0; k < 60; k++) begin
            int idx;
            if ($urandom_range(3) == 0) cyc(0, 0);
            cyc(1, $urandom);
            idx = (k / 4) % 14;
            check("t3_tri", 32'(bus.counter), 32'(idx <= 7 ? idx : 14 - idx));
        end

        // Depth lowered under the phase: snap to new apex and fall.
        en = 1'b0;
        cyc(0, 0);
        en = 1'b1; rate = 0; depth = 3'd7;
        for (int i = 0; i < 5; i++) cyc(1, $urandom);
        depth = 3'd3;
        for (int i = 0; i < 6; i++) begin
            cyc(1, $urandom);
            check("t4_seq", 32'(bus.counter), 32'(exp4[i]));
        end

        // Enable drops together with a sample at phase 4, then restarts.
        en = 1'b0;
        cyc(0, 0);
        en = 1'b1; rate = 0; depth = 3'd7;
        for (int i = 0; i < 4; i++) cyc(1, $urandom);
        en = 1'b0;
        cyc(1, 32'hDEAD_BEEF);
        check("t5_off_cnt", 32'(bus.counter), 32'd0);
        check("t5_off_en",  32'(bus.en_out), 32'd0);
        en = 1'b1;
        cyc(0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, $urandom);
            check("t5_restart", 32'(bus.counter), 32'(i));
        end

        // Reset pulse while a sample is in flight: sample dropped.
        cyc(1, $urandom);
        bus.s_valid = 1'b1;
        bus.x_in    = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_cnt", 32'(bus.counter), 32'd0);
        check("t6_async_en",  32'(bus.en_out), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("t6_m_valid", 32'(bus.m_valid), 32'd0);
        check("t6_x_out",   bus.x_out, 32'd0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 32'h0BAD_F00D);
        check("t6_post_cnt", 32'(bus.counter), 32'd0);

        // Randomized run with enable, rate and depth changing on the fly.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) en = ~en;
            if ($urandom_range(49) == 0) rate = RW'($urandom_range(3));
            if ($urandom_range(29) == 0) depth = 3'($urandom_range(7));
            cyc(1'($urandom_range(1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
